count_monitor: RTL

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_monitor_pkg.sv | 14 +
 rtl/count_monitor_sat_counter.sv | 29 ++
 rtl/count_monitor.sv | 116 +++++++++++
 3 files changed

// File: rtl/count_monitor_pkg.sv
// Shared definitions for the count_monitor block.
//   state_t : FSM state encodings, also visible on the state output port
//   CNT_MAX : terminal value of the monitored 4-bit upstream counter
package count_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        ERROR = 2'b10
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'd15;

endpackage

// File: rtl/count_monitor_sat_counter.sv
// Saturating up-counter. It stops at all-ones and does not roll over.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   clr   : synchronous clear; takes priority over inc
//   inc   : add one on this edge unless already saturated
//   q     : counter value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] QMAX = {W{1'b1}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != QMAX)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/count_monitor.sv
// Monitors an upstream 4-bit counter. It flags wraps and restarts as
// one-cycle pulses and latches any sequence violation.
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   en         : sample strobe for q
//   q          : upstream count value
//   clr        : synchronous clear of the monitor state and statistics
//   wrap_pulse : registered pulse after a legal 15->0 step
//   restart    : registered pulse after a legal mid-sequence return to 0
//   err        : sticky violation flag
//   wrap_cnt   : saturating count of wrap events
//   state      : current FSM state
//
// state | meaning
// IDLE  | no history yet; the next sample seeds prev
// TRACK | following the count; prev holds the last sample
// ERROR | a violation was seen; only clr or reset leaves this state
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [3:0]        q,
    input  logic              clr,
    output logic              wrap_pulse,
    output logic              restart,
    output logic              err,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [1:0]        state
);

    state_t     state_q, state_nxt;
    logic [3:0] prev_q, prev_nxt;
    logic       wrap_nxt, restart_nxt, err_nxt;

    always_comb begin
        state_nxt   = state_q;
        prev_nxt    = prev_q;
        wrap_nxt    = 1'b0;
        restart_nxt = 1'b0;
        err_nxt     = err_q_sel();
        if (clr) begin
            state_nxt = IDLE;
            prev_nxt  = 4'd0;
            err_nxt   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en) begin
                        prev_nxt  = q;
                        state_nxt = TRACK;
                    end
                end
                TRACK: begin
                    if (en) begin
                        if (q == prev_q + 4'd1) begin
                            prev_nxt = q;
                            wrap_nxt = (prev_q == CNT_MAX);
                        end else if (q == prev_q) begin
                            // A repeated sample (including 0 after 0) is a hold.
                            prev_nxt = prev_q;
                        end else if (q == 4'd0) begin
                            restart_nxt = 1'b1;
                            prev_nxt    = 4'd0;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = ERROR;
                        end
                    end
                end
                ERROR: begin
                    err_nxt = 1'b1;
                end
                default: begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b0;
                end
            endcase
        end
    end

    function automatic logic err_q_sel();
        return err;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            prev_q     <= 4'd0;
            wrap_pulse <= 1'b0;
            restart    <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            prev_q     <= prev_nxt;
            wrap_pulse <= wrap_nxt;
            restart    <= restart_nxt;
            err        <= err_nxt;
        end
    end

    // The counter increments on the same edge that registers wrap_pulse.
    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (wrap_nxt),
        .q     (wrap_cnt)
    );

    assign state = state_q;

endmodule
